// File: rtl/fir_pkg.sv
// Shared parameters, RAM address layout and output saturation for the
// reconfigurable FIR filter.
package fir_pkg;

  localparam int TAPS       = 20;
  localparam int BANK_DEPTH = 10;
  localparam int COEF_W     = 16;
  localparam int IN_W       = 3;
  localparam int ACC_W      = 24;
  localparam int MUL_W      = COEF_W + IN_W;
  localparam int IDX_W      = 5;

  localparam logic [1:0] BANK_A = 2'b00;
  localparam logic [1:0] BANK_B = 2'b01;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 24'sh007FFF;
  localparam logic signed [ACC_W-1:0] SAT_MIN = 24'shFF8000;

  typedef struct packed {
    logic [1:0] bank;
    logic [3:0] word;
  } ram_addr_t;

  function automatic logic [COEF_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      return 16'h7FFF;
    end else if (v < SAT_MIN) begin
      return 16'h8000;
    end else begin
      return v[COEF_W-1:0];
    end
  endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// One 10 x 16 coefficient register file: synchronous write, registered read
// that returns 0 when not reading or when the word is out of range.
module fir_coeff_bank
  import fir_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  input  logic [3:0]        addr_i,
  input  logic [COEF_W-1:0] wdata_i,
  output logic [COEF_W-1:0] rdata_o
);

  logic [COEF_W-1:0] mem_q [BANK_DEPTH];
  logic [COEF_W-1:0] rdata_q;
  logic              addr_ok_s;

  assign addr_ok_s = (addr_i < 4'(BANK_DEPTH));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < BANK_DEPTH; k++) begin
        mem_q[k] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (wr_en_i && addr_ok_s) begin
        mem_q[addr_i] <= wdata_i;
      end
      if (rd_en_i && addr_ok_s) begin
        rdata_q <= mem_q[addr_i];
      end else begin
        rdata_q <= '0;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/reconf_fir_filter.sv
// 20-tap FIR with sequencer-driven coefficient reads: delay line, read mux,
// registered multiplier, accumulator and saturated output register.
module reconf_fir_filter
  import fir_pkg::*;
(
  input  logic              iClk12M,
  input  logic              iRsn,
  input  logic              iEnSample600k,
  input  logic              iCoeffUpdateFlag,
  input  logic              iCsnRam,
  input  logic              iWrnRam,
  input  logic              iEnMul,
  input  logic              iEnAddAcc,
  input  logic [5:0]        iAddrRam,
  input  logic [COEF_W-1:0] iWtDtRam,
  input  logic [IN_W-1:0]   iFirIn,
  output logic [COEF_W-1:0] oFirOut
);

  ram_addr_t                addr_s;
  logic                     wr_s;
  logic                     rd_s;
  logic                     word_ok_s;
  logic [COEF_W-1:0]        coef_a_s;
  logic [COEF_W-1:0]        coef_b_s;
  logic [COEF_W-1:0]        coef_s;
  logic [IN_W-1:0]          sample_s;
  logic signed [MUL_W-1:0]  mul_s;

  logic [IN_W-1:0]          taps_q [TAPS];
  logic [IDX_W-1:0]         tap_idx_q, tap_idx_d;
  logic signed [ACC_W-1:0]  prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [COEF_W-1:0]        out_q, out_d;

  assign addr_s    = iAddrRam;
  assign wr_s      = iCoeffUpdateFlag & ~iCsnRam & ~iWrnRam;
  assign rd_s      = ~iCoeffUpdateFlag & ~iCsnRam & iWrnRam;
  assign word_ok_s = (addr_s.word < 4'(BANK_DEPTH));

  fir_coeff_bank u_bank_a (
    .clk_i   (iClk12M),
    .rst_i   (iRsn),
    .wr_en_i (wr_s && (addr_s.bank == BANK_A)),
    .rd_en_i (rd_s && (addr_s.bank == BANK_A)),
    .addr_i  (addr_s.word),
    .wdata_i (iWtDtRam),
    .rdata_o (coef_a_s)
  );

  fir_coeff_bank u_bank_b (
    .clk_i   (iClk12M),
    .rst_i   (iRsn),
    .wr_en_i (wr_s && (addr_s.bank == BANK_B)),
    .rd_en_i (rd_s && (addr_s.bank == BANK_B)),
    .addr_i  (addr_s.word),
    .wdata_i (iWtDtRam),
    .rdata_o (coef_b_s)
  );

  // At most one bank read register is non-zero, so OR acts as the bank mux.
  assign coef_s   = coef_a_s | coef_b_s;
  assign sample_s = taps_q[tap_idx_q];
  assign mul_s    = $signed({{IN_W{coef_s[COEF_W-1]}}, coef_s})
                  * $signed({{COEF_W{sample_s[IN_W-1]}}, sample_s});

  always_comb begin
    tap_idx_d = 5'd0;
    if (rd_s && word_ok_s) begin
      case (addr_s.bank)
        BANK_A:  tap_idx_d = {1'b0, addr_s.word};
        BANK_B:  tap_idx_d = {1'b0, addr_s.word} + 5'(BANK_DEPTH);
        default: tap_idx_d = 5'd0;
      endcase
    end else begin
      tap_idx_d = 5'd0;
    end
  end

  // The strobe restarts the sum with the product being added in the same cycle.
  always_comb begin
    prod_d = prod_q;
    acc_d  = acc_q;
    out_d  = out_q;
    if (iEnMul) begin
      prod_d = {{(ACC_W-MUL_W){mul_s[MUL_W-1]}}, mul_s};
    end else begin
      prod_d = prod_q;
    end
    if (iEnSample600k) begin
      out_d = sat16(acc_q);
      acc_d = iEnAddAcc ? prod_q : '0;
    end else if (iEnAddAcc) begin
      acc_d = acc_q + prod_q;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge iClk12M) begin
    if (iRsn) begin
      for (int k = 0; k < TAPS; k++) begin
        taps_q[k] <= '0;
      end
      tap_idx_q <= '0;
      prod_q    <= '0;
      acc_q     <= '0;
      out_q     <= '0;
    end else begin
      if (iEnSample600k) begin
        taps_q[0] <= iFirIn;
        for (int k = 1; k < TAPS; k++) begin
          taps_q[k] <= taps_q[k-1];
        end
      end
      tap_idx_q <= tap_idx_d;
      prod_q    <= prod_d;
      acc_q     <= acc_d;
      out_q     <= out_d;
    end
  end

  assign oFirOut = out_q;

endmodule

// File: tb/tb_reconf_fir_filter.sv
// Self-checking bench: expected oFirOut values are queued when a strobe is
// driven and compared after the strobe edge.
module tb_reconf_fir_filter;

  logic        clk = 1'b0;
  logic        rsn;
  logic        en_sample;
  logic        flag;
  logic        csn;
  logic        wrn;
  logic        en_mul;
  logic        en_add;
  logic [5:0]  addr;
  logic [15:0] wdata;
  logic [2:0]  fir_in;
  logic [15:0] fir_out;

  logic [15:0] exp_q [$];
  logic [15:0] last_out;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          imp;

  always #5 clk = ~clk;

  reconf_fir_filter dut (
    .iClk12M          (clk),
    .iRsn             (rsn),
    .iEnSample600k    (en_sample),
    .iCoeffUpdateFlag (flag),
    .iCsnRam          (csn),
    .iWrnRam          (wrn),
    .iEnMul           (en_mul),
    .iEnAddAcc        (en_add),
    .iAddrRam         (addr),
    .iWtDtRam         (wdata),
    .iFirIn           (fir_in),
    .oFirOut          (fir_out)
  );

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty, got %h", tag, fir_out);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, fir_out, e);
      last_out = e;
    end
  endtask

  task automatic idle();
    en_sample = 1'b0; flag = 1'b0; csn = 1'b1; wrn = 1'b1;
    en_mul = 1'b0; en_add = 1'b0; addr = 6'd0; wdata = 16'h0000;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic flg);
    flag = flg; csn = 1'b0; wrn = 1'b0; addr = a; wdata = d;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic strobe(input logic [2:0] s, input logic [15:0] exp);
    en_sample = 1'b1; fir_in = s;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    en_sample = 1'b0; fir_in = 3'b000;
    pop_check("strobe");
  endtask

  // Sequencer burst over taps start..start+n-1; optional strobe on the last add cycle.
  task automatic burst(input int start, input int n, input logic flg, input bit use_fix,
                       input logic [5:0] fix_addr, input bit coll, input logic [15:0] coll_exp);
    int k;
    for (int i = 0; i < n + 2; i++) begin
      k = start + i;
      flag   = flg;
      csn    = (i < n) ? 1'b0 : 1'b1;
      wrn    = 1'b1;
      addr   = use_fix ? fix_addr : {2'(k / 10), 4'(k % 10)};
      en_mul = (i >= 1 && i <= n);
      en_add = (i >= 2 && i <= n + 1);
      if (coll && i == n + 1) begin
        en_sample = 1'b1; fir_in = 3'b011;
        exp_q.push_back(coll_exp);
      end
      @(posedge clk); #1;
      if (coll && i == n + 1) begin
        en_sample = 1'b0;
        pop_check("collide");
      end
    end
    idle();
    check_eq("hold", fir_out, last_out);
  endtask

  function automatic logic [15:0] imp_exp(input int p);
    int c;
    c = (p < 10) ? (2560 + p) : (2816 + p - 10);
    return 16'(-c);
  endfunction

  initial begin
    idle();
    fir_in = 3'b000;
    rsn = 1'b1;
    last_out = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_out", fir_out, 16'h0000);
    rsn = 1'b0;

    for (int w = 0; w < 10; w++) wr({2'b00, 4'(w)}, 16'h0A00 + 16'(w), 1'b1);
    for (int w = 0; w < 10; w++) wr({2'b01, 4'(w)}, 16'h0B00 + 16'(w), 1'b1);
    wr(6'b01_0001, 16'h7777, 1'b0);
    wr(6'b00_1100, 16'h7777, 1'b1);
    wr(6'b10_0001, 16'h7777, 1'b1);
    wr(6'b11_0001, 16'h7777, 1'b1);

    // impulse walks through bank A then bank B
    strobe(3'b111, 16'h0000);
    burst(0, 10, 1'b0, 1'b0, 6'd0, 1'b0, 16'h0);
    strobe(3'b000, 16'hF600);
    burst(0, 10, 1'b0, 1'b0, 6'd0, 1'b0, 16'h0);
    strobe(3'b000, 16'hF5FF);
    imp = 2;
    while (imp < 10) begin
      strobe(3'b000, 16'h0000);
      imp++;
    end
    burst(10, 10, 1'b0, 1'b0, 6'd0, 1'b0, 16'h0);
    strobe(3'b000, 16'hF500);
    imp = 11;
    burst(0, 20, 1'b0, 1'b0, 6'd0, 1'b0, 16'h0);
    strobe(3'b000, imp_exp(imp));
    imp = 12;

    // blocked and invalid reads contribute nothing
    burst(0, 20, 1'b1, 1'b0, 6'd0, 1'b0, 16'h0);
    strobe(3'b000, 16'h0000);
    burst(0, 1, 1'b0, 1'b1, 6'b00_1101, 1'b0, 16'h0);
    strobe(3'b000, 16'h0000);
    burst(0, 1, 1'b0, 1'b1, 6'b11_0100, 1'b0, 16'h0);
    strobe(3'b000, 16'h0000);

    // positive saturation
    for (int w = 0; w < 10; w++) wr({2'b00, 4'(w)}, 16'h7FFF, 1'b1);
    for (int w = 0; w < 10; w++) wr({2'b01, 4'(w)}, 16'h7FFF, 1'b1);
    for (int i = 0; i < 20; i++) strobe(3'b011, 16'h0000);
    burst(0, 20, 1'b0, 1'b0, 6'd0, 1'b0, 16'h0);
    strobe(3'b011, 16'h7FFF);

    // strobe collides with the last accumulate: products 3 then 6
    wr(6'b00_0000, 16'h0001, 1'b1);
    wr(6'b00_0001, 16'h0002, 1'b1);
    burst(0, 2, 1'b0, 1'b0, 6'd0, 1'b1, 16'h0003);
    strobe(3'b011, 16'h0006);

    // negative saturation
    wr(6'b00_0000, 16'h7FFF, 1'b1);
    wr(6'b00_0001, 16'h7FFF, 1'b1);
    for (int i = 0; i < 20; i++) strobe(3'b100, 16'h0000);
    burst(0, 20, 1'b0, 1'b0, 6'd0, 1'b0, 16'h0);
    strobe(3'b100, 16'h8000);

    // reset in the middle of an accumulating burst
    for (int i = 0; i < 8; i++) begin
      csn = 1'b0; wrn = 1'b1; addr = {2'b00, 4'(i)};
      en_mul = (i >= 1); en_add = (i >= 2);
      @(posedge clk); #1;
    end
    rsn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_mid_out", fir_out, 16'h0000);
    rsn = 1'b0;
    idle();
    last_out = 16'h0000;
    for (int i = 0; i < 20; i++) strobe(3'b011, 16'h0000);
    burst(0, 20, 1'b0, 1'b0, 6'd0, 1'b0, 16'h0);
    strobe(3'b011, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
